// File: rtl/alu_seq.sv
// Multi-byte ALU sequencer: splits one 8..32-bit request into per-byte SETUP/EXEC
// steps, chaining the logic carry and folding per-byte flags into one result set.
module alu_seq #(
  parameter int BYTES_W = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [3:0]         OpFirst,
  input  logic [3:0]         OpRest,
  input  logic [BYTES_W-1:0] ByteCount,
  input  logic               MsbFirst,
  input  logic               CarryIn,
  input  logic [4:0]         FlagsIn,
  output logic               Busy,
  output logic               Done,
  output logic [BYTES_W-1:0] ByteSel,
  output logic [3:0]         AluOp,
  output logic               Alu_Assert,
  output logic               LCarryIn,
  output logic [4:0]         FlagsOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [BYTES_W:0]   step;
  logic [BYTES_W-1:0] count_q;
  logic [3:0]         op_first_q;
  logic [3:0]         op_rest_q;
  logic               msb_first_q;
  logic               carry_in_q;
  logic               carry_q;
  logic               zero_acc;
  logic               sign_acc;

  logic [BYTES_W-1:0] byte_sel;
  logic               last_step;
  logic               first_step;
  logic               msb_byte;

  // The counter is one bit wider than ByteCount so an all-ones count still terminates.
  assign first_step = (step == '0);
  assign last_step  = (step == {1'b0, count_q});
  assign byte_sel   = msb_first_q ? (count_q - step[BYTES_W-1:0]) : step[BYTES_W-1:0];
  assign msb_byte   = (byte_sel == count_q);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    Alu_Assert = 1'b1;
    AluOp      = 4'd0;
    ByteSel    = '0;
    LCarryIn   = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          next_state = SETUP;
        end
      end
      SETUP: begin
        Busy       = 1'b1;
        AluOp      = first_step ? op_first_q : op_rest_q;
        ByteSel    = byte_sel;
        LCarryIn   = first_step ? carry_in_q : carry_q;
        next_state = EXEC;
      end
      EXEC: begin
        Busy       = 1'b1;
        Alu_Assert = 1'b0;
        AluOp      = first_step ? op_first_q : op_rest_q;
        ByteSel    = byte_sel;
        LCarryIn   = first_step ? carry_in_q : carry_q;
        next_state = last_step ? DONE : SETUP;
      end
      DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch, step counter and flag accumulation. FlagsOut is written on the
  // last EXEC edge so it is already valid in the DONE cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      step        <= '0;
      count_q     <= '0;
      op_first_q  <= 4'd0;
      op_rest_q   <= 4'd0;
      msb_first_q <= 1'b0;
      carry_in_q  <= 1'b0;
      carry_q     <= 1'b0;
      zero_acc    <= 1'b1;
      sign_acc    <= 1'b0;
      FlagsOut    <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            op_first_q  <= OpFirst;
            op_rest_q   <= OpRest;
            count_q     <= ByteCount;
            msb_first_q <= MsbFirst;
            carry_in_q  <= CarryIn;
            step        <= '0;
            carry_q     <= 1'b0;
            zero_acc    <= 1'b1;
            sign_acc    <= 1'b0;
          end
        end
        EXEC: begin
          zero_acc <= zero_acc & FlagsIn[2];
          carry_q  <= FlagsIn[4];
          if (msb_byte) begin
            sign_acc <= FlagsIn[1];
          end
          if (last_step) begin
            FlagsOut <= {FlagsIn[4], FlagsIn[3], zero_acc & FlagsIn[2],
                         msb_byte ? FlagsIn[1] : sign_acc, FlagsIn[0]};
          end else begin
            step <= step + {{BYTES_W{1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: table of multi-byte requests scored against per-step and
// per-request expectation queues, plus busy-start and reset corner sequences.
module tb_alu_seq;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [3:0] OpFirst;
  logic [3:0] OpRest;
  logic [1:0] ByteCount;
  logic       MsbFirst;
  logic       CarryIn;
  logic [4:0] FlagsIn;
  logic       Busy;
  logic       Done;
  logic [1:0] ByteSel;
  logic [3:0] AluOp;
  logic       Alu_Assert;
  logic       LCarryIn;
  logic [4:0] FlagsOut;

  int checks = 0;
  int errors = 0;

  alu_seq #(.BYTES_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .OpFirst(OpFirst), .OpRest(OpRest),
    .ByteCount(ByteCount), .MsbFirst(MsbFirst), .CarryIn(CarryIn), .FlagsIn(FlagsIn),
    .Busy(Busy), .Done(Done), .ByteSel(ByteSel), .AluOp(AluOp),
    .Alu_Assert(Alu_Assert), .LCarryIn(LCarryIn), .FlagsOut(FlagsOut)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] op;
    logic       lc;
    logic [4:0] fl;
  } step_t;

  // Per-step fields are packed with step 0 in the low slice.
  typedef struct packed {
    logic [1:0]  cnt;
    logic        msb;
    logic [3:0]  op_first;
    logic [3:0]  op_rest;
    logic        cin;
    logic [19:0] fl;
    logic [7:0]  exp_sel;
    logic [3:0]  exp_lc;
    logic [4:0]  exp_flags;
  } vec_t;

  step_t      step_q[$];
  logic [4:0] flags_q[$];
  vec_t       vecs[6];
  step_t      mon_e;
  logic [4:0] mon_f;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard: SETUP/EXEC cycles are checked against the head step, EXEC consumes
  // it and answers with that step's ALU flags; Done consumes the request's flags.
  always @(negedge Clock) begin
    if (Busy && !Done && Alu_Assert && step_q.size() > 0) begin
      checkOutput("setup_bytesel", 32'(ByteSel), 32'(step_q[0].sel));
      checkOutput("setup_aluop", 32'(AluOp), 32'(step_q[0].op));
      checkOutput("setup_lcarry", 32'(LCarryIn), 32'(step_q[0].lc));
    end
    if (!Alu_Assert) begin
      if (step_q.size() == 0) begin
        checkOutput("unexpected_exec", 32'd1, 32'd0);
      end else begin
        mon_e = step_q.pop_front();
        checkOutput("exec_bytesel", 32'(ByteSel), 32'(mon_e.sel));
        checkOutput("exec_aluop", 32'(AluOp), 32'(mon_e.op));
        checkOutput("exec_lcarry", 32'(LCarryIn), 32'(mon_e.lc));
        FlagsIn = mon_e.fl;
      end
    end
    if (Done) begin
      if (flags_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_f = flags_q.pop_front();
        checkOutput("done_flags", 32'(FlagsOut), 32'(mon_f));
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    step_t st;
    for (int s = 0; s <= int'(v.cnt); s++) begin
      st.sel = v.exp_sel[2*s +: 2];
      st.op  = (s == 0) ? v.op_first : v.op_rest;
      st.lc  = v.exp_lc[s];
      st.fl  = v.fl[5*s +: 5];
      step_q.push_back(st);
    end
    flags_q.push_back(v.exp_flags);
    OpFirst   = v.op_first;
    OpRest    = v.op_rest;
    ByteCount = v.cnt;
    MsbFirst  = v.msb;
    CarryIn   = v.cin;
    Start     = 1'b1;
  endtask

  // Runs one request from acceptance; request inputs are scrambled while busy.
  task automatic runRequest(input vec_t v, input int inject_k, input int reset_k);
    int n        = int'(v.cnt) + 1;
    int last_k   = 2 * n + 2;
    int done_k   = -1;
    int done_cnt = 0;
    int low      = 0;
    logic exp_busy;
    applyStimulus(v);
    @(posedge Clock);
    for (int k = 1; k <= last_k; k++) begin
      @(negedge Clock);
      OpFirst   = 4'($urandom);
      OpRest    = 4'($urandom);
      ByteCount = 2'($urandom);
      MsbFirst  = 1'($urandom);
      CarryIn   = 1'($urandom);
      Start     = (k == inject_k);
      if (reset_k > 0 && k == reset_k) Reset = 1'b1;
      if (reset_k > 0 && k == reset_k + 1) begin
        Reset = 1'b0;
        checkOutput("rst_alu_assert", 32'(Alu_Assert), 32'd1);
        checkOutput("rst_flags", 32'(FlagsOut), 32'd0);
        step_q.delete();
        flags_q.delete();
      end
      if (Done) begin
        done_cnt++;
        done_k = k;
      end
      if (!Alu_Assert) low++;
      exp_busy = (reset_k > 0) ? (k <= reset_k) : (k <= 2 * n + 1);
      checkOutput("busy", 32'(Busy), 32'(exp_busy));
    end
    Start = 1'b0;
    checkOutput("done_count", 32'(done_cnt), (reset_k > 0) ? 32'd0 : 32'd1);
    checkOutput("done_cycle", 32'(done_k), (reset_k > 0) ? 32'hFFFF_FFFF : 32'(2 * n + 1));
    checkOutput("exec_cycles", 32'(low), (reset_k > 0) ? 32'(reset_k / 2) : 32'(n));
    if (reset_k == 0) checkOutput("flags_hold", 32'(FlagsOut), 32'(v.exp_flags));
  endtask

  task automatic resetWithStart();
    OpFirst   = 4'h5;
    ByteCount = 2'd1;
    Start     = 1'b1;
    Reset     = 1'b1;
    @(negedge Clock);
    checkOutput("rst_start_busy", 32'(Busy), 32'd0);
    checkOutput("rst_start_flags", 32'(FlagsOut), 32'd0);
    Start = 1'b0;
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("rst_start_idle", 32'(Busy), 32'd0);
    checkOutput("rst_start_assert", 32'(Alu_Assert), 32'd1);
  endtask

  initial begin
    Reset     = 1'b1;
    Start     = 1'b0;
    OpFirst   = 4'd0;
    OpRest    = 4'd0;
    ByteCount = 2'd0;
    MsbFirst  = 1'b0;
    CarryIn   = 1'b0;
    FlagsIn   = 5'd0;

    //          cnt   msb   opF    opR    cin   flags per step (step3..step0)                      sel     lc       flags
    vecs[0] = '{2'd0, 1'b0, 4'h3, 4'h5, 1'b1, {15'd0, 5'b00100},                                 8'h00, 4'b0001, 5'b00100};
    vecs[1] = '{2'd3, 1'b0, 4'h1, 4'h9, 1'b0, {5'b01011, 5'b00000, 5'b10000, 5'b00000},          8'hE4, 4'b0100, 5'b01011};
    vecs[2] = '{2'd1, 1'b1, 4'h2, 4'h6, 1'b0, {10'd0, 5'b00000, 5'b00110},                       8'h01, 4'b0000, 5'b00010};
    vecs[3] = '{2'd1, 1'b1, 4'h2, 4'h6, 1'b0, {10'd0, 5'b00100, 5'b10110},                       8'h01, 4'b0010, 5'b00110};
    vecs[4] = '{2'd3, 1'b1, 4'hA, 4'hB, 1'b1, {5'b00101, 5'b01100, 5'b10100, 5'b00111},          8'h1B, 4'b0101, 5'b00111};
    vecs[5] = '{2'd2, 1'b0, 4'h7, 4'h8, 1'b1, {5'd0, 5'b00011, 5'b00000, 5'b11000},              8'h24, 4'b0011, 5'b00011};

    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_done", 32'(Done), 32'd0);
    checkOutput("reset_assert", 32'(Alu_Assert), 32'd1);
    checkOutput("reset_aluop", 32'(AluOp), 32'd0);
    checkOutput("reset_bytesel", 32'(ByteSel), 32'd0);
    checkOutput("reset_lcarry", 32'(LCarryIn), 32'd0);
    checkOutput("reset_flags", 32'(FlagsOut), 32'd0);

    for (int i = 0; i < 6; i++) begin
      runRequest(vecs[i], 0, 0);
    end

    // Start pulse during a busy 2-byte request, then an immediate follow-on request.
    runRequest(vecs[2], 3, 0);
    runRequest(vecs[5], 0, 0);

    // Reset during the EXEC of step 1 of a 4-byte request.
    runRequest(vecs[1], 0, 4);
    resetWithStart();
    runRequest(vecs[0], 0, 0);

    checkOutput("scoreboard_steps_empty", 32'(step_q.size()), 32'd0);
    checkOutput("scoreboard_flags_empty", 32'(flags_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-byte operation sequencer for the 8-bit ALU. It accepts one 8/16/24/32-bit ALU request and breaks it into per-byte ALU steps. For each byte it drives the ALU opcode lines, the register byte select, `LCarryIn` and the active-low `Alu_Assert`. It chains the logic carry between bytes and accumulates the flags into a single result flag set. It sits between the pipeline stage-1 decode and the ALU, and owns the ALU whenever `Busy` is high.

## Interface
- `BYTES_W`, default 2: width of the byte-count and byte-select fields. The maximum request length is 2^BYTES_W bytes.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous reset, active-high.
- `Start`  in  1  request strobe; accepted only when `Busy`=0.
- `OpFirst`  in  4  ALU opcode for the first byte processed.
- `OpRest`  in  4  ALU opcode for the remaining bytes (e.g. the carry-chained variant).
- `ByteCount`  in  BYTES_W  number of bytes minus 1 (0 means 1 byte).
- `MsbFirst`  in  1  byte order: 0 processes byte 0 upward, 1 processes byte N-1 downward.
- `CarryIn`  in  1  `LCarryIn` value for the first byte.
- `FlagsIn`  in  5  ALU flags {CarryL, CarryA, Zero, Sign, Overflow}, bits [4:0].
- `Busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `Done`  out  1  one-cycle pulse; `FlagsOut` is valid from this cycle on.
- `ByteSel`  out  BYTES_W  register byte index for the current step.
- `AluOp`  out  4  drives ALUOP3..0 on the ALU.
- `Alu_Assert`  out  1  active-low ALU result enable onto MainBus.
- `LCarryIn`  out  1  logic/shift carry into the ALU.
- `FlagsOut`  out  5  accumulated flags, same bit order as `FlagsIn`.

## Operation
- The state machine has four states: IDLE, SETUP, EXEC, DONE.
- In IDLE with `Start`=1:
  - Latch `OpFirst`, `OpRest`, `ByteCount`, `MsbFirst` and `CarryIn`.
  - Clear the step counter, set the Zero accumulator to 1, then go to SETUP.
- SETUP:
  - Drive `AluOp` (`OpFirst` on step 0, `OpRest` otherwise), `ByteSel` and `LCarryIn`.
  - `Alu_Assert`=1. Go to EXEC.
- EXEC:
  - `AluOp`, `ByteSel` and `LCarryIn` are held. `Alu_Assert`=0.
  - At the clock edge, sample `FlagsIn`:
    - zero_acc &= Zero.
    - Sign is captured when the byte index equals `ByteCount`, i.e. from the most-significant byte.
    - Overflow, CarryA and CarryL are captured from every step, so the last step wins.
    - The carry register is set to CarryL.
  - If step == `ByteCount`, go to DONE. Otherwise increment step and go to SETUP.
- DONE:
  - `Done`=1 and `FlagsOut` is updated. Go to IDLE.
- `ByteSel` is step when `MsbFirst`=0, and `ByteCount`-step when `MsbFirst`=1.
- `LCarryIn` is the latched `CarryIn` on step 0. On later steps it is the CarryL captured in the previous EXEC.
- `Start` while `Busy`=1 is ignored: no queueing and no effect on the request in progress.
- Request fields are only sampled at acceptance; input changes during `Busy` have no effect.
- The step counter is BYTES_W+1 bits wide, so `ByteCount` = all-ones never wraps.

## Timing
- Reset values:
  - State IDLE.
  - `Busy`=0, `Done`=0, `Alu_Assert`=1, `AluOp`=0, `ByteSel`=0, `LCarryIn`=0, `FlagsOut`=0.
- All outputs are registered or decoded from state; none is combinational from inputs.
- Each byte takes 2 cycles (SETUP, EXEC). The ALU latches its opcode during SETUP, and the result is valid on MainBus during EXEC.
- `Start` accepted at edge T:
  - `Busy` rises at T+1.
  - First EXEC is at cycle T+2.
  - `Done` pulses at cycle T+2N+1, where N = `ByteCount`+1.
  - `Busy` falls at T+2N+2.
- The earliest next acceptance is the edge ending cycle T+2N+2, i.e. back-to-back requests with 1 idle cycle.
- `FlagsOut` holds its value until the next request's DONE.
- `Reset` asserted in any state returns to IDLE on that edge:
  - `Alu_Assert` returns to 1 and no `Done` is generated.
  - `FlagsOut` is cleared.
- `Reset` and `Start` in the same cycle: `Reset` wins and the request is dropped.

## Test plan
- **Single byte.** `ByteCount`=0, `OpFirst`=4'h3, `CarryIn`=1, `FlagsIn`=5'b00100 during EXEC:
  - `AluOp`=3 and `LCarryIn`=1 for 2 cycles; `Alu_Assert` is low exactly 1 cycle.
  - `Done` at T+3; `FlagsOut`=5'b00100.
- **Four bytes, LSB first.** `ByteCount`=3, `OpFirst`=1, `OpRest`=9, `FlagsIn` CarryL=1 on step 1 only:
  - `ByteSel` 0,1,2,3; `AluOp` 1,9,9,9.
  - `LCarryIn` 0,0,1,0 on steps 0..3.
  - `Done` at T+9.
- **Zero/sign accumulation.** 2 bytes, MSB first, Zero=1 then 0, Sign=1 on byte 1:
  - `ByteSel` 1,0.
  - `FlagsOut` Zero=0 and Sign=1.
  - The test is repeated with Zero=1 on both bytes, giving Zero=1.
- **Start while busy.** Second `Start` pulse at T+3 of a 2-byte request:
  - It is ignored: exactly one `Done` at T+5 and `AluOp` unchanged.
  - A `Start` at T+6 is accepted.
- **Reset mid-operation.** `Reset` in the EXEC of step 1 of a 4-byte request:
  - Next cycle IDLE, `Alu_Assert`=1, `Busy`=0, `FlagsOut`=0, no `Done`.
- **Max count.** `BYTES_W`=2, `ByteCount`=3 with `MsbFirst`=1:
  - `ByteSel` 3,2,1,0.
  - Terminates after exactly 4 EXEC cycles with no counter wrap.
